// File: rtl/sudoku_pkg.sv
// Shared types and 100 MHz timing defaults for the event stretcher output path.
// Consumers: event_stretcher (optionally built with EVENT_STRETCHER_QUEUE_EN), stretch_timer.
package sudoku_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } stretch_state_t;

  localparam int DEFAULT_ON_CYCLES   = 5_000_000;
  localparam int DEFAULT_GAP_CYCLES  = 2_500_000;
  localparam int DEFAULT_MAX_PENDING = 7;

  // Down-counter width: wide enough for the larger reload value, never zero bits.
  function automatic int timer_width(input int on_c, input int gap_c);
    int m;
    int w;
    m = (on_c > gap_c) ? on_c : gap_c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stretch_timer.sv
// Loadable down-counter; done flags terminal count (zero). Parked at zero until reloaded.
module stretch_timer
  import sudoku_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/event_stretcher.sv
// Stretches one-cycle event pulses into ON/GAP output intervals for LEDs or a buzzer.
// Define EVENT_STRETCHER_QUEUE_EN to replay events that arrive while busy; otherwise they are dropped.
//
// state   | meaning
// IDLE    | output low, nothing pending, waiting for trigger
// ON      | output high for ON_CYCLES
// GAP     | forced low for GAP_CYCLES before the next ON or IDLE
module event_stretcher
  import sudoku_pkg::*;
#(
  parameter int ON_CYCLES   = DEFAULT_ON_CYCLES,
  parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int MAX_PENDING = DEFAULT_MAX_PENDING
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               trigger,
  input  logic                               clear,
  output logic                               out_level,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  localparam int TW = timer_width(ON_CYCLES, GAP_CYCLES);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  stretch_state_t state_q, state_d;
  logic           out_level_q, out_level_d;
  logic           busy_q, busy_d;
  logic           overflow_q, overflow_d;
  logic           enq;

  logic           tmr_load;
  logic [TW-1:0]  tmr_value;
  logic           tmr_enable;
  logic           tmr_done;

`ifdef EVENT_STRETCHER_QUEUE_EN
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);
  logic [PW-1:0] pending_q, pending_d;
`endif

  stretch_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .enable     (tmr_enable),
    .done       (tmr_done)
  );

  assign tmr_enable = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_value  = ON_LOAD;
    overflow_d = 1'b0;
    enq        = 1'b0;
`ifdef EVENT_STRETCHER_QUEUE_EN
    pending_d  = pending_q;
`endif
    if (clear) begin
      state_d = ST_IDLE;
`ifdef EVENT_STRETCHER_QUEUE_EN
      pending_d = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_d  = ST_ON;
            tmr_load = 1'b1;
          end
        end
        ST_ON: begin
          if (tmr_done) begin
            state_d   = ST_GAP;
            tmr_load  = 1'b1;
            tmr_value = GAP_LOAD;
          end
          enq = trigger;
        end
        ST_GAP: begin
          if (tmr_done) begin
`ifdef EVENT_STRETCHER_QUEUE_EN
            // A trigger on the last GAP cycle takes the slot of the event being replayed.
            if (pending_q != '0) begin
              state_d   = ST_ON;
              tmr_load  = 1'b1;
              pending_d = trigger ? pending_q : pending_q - PEND_ONE;
            end else if (trigger) begin
`else
            if (trigger) begin
`endif
              state_d  = ST_ON;
              tmr_load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            enq = trigger;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (enq) begin
`ifdef EVENT_STRETCHER_QUEUE_EN
        if (pending_q < PEND_MAX) begin
          pending_d = pending_q + PEND_ONE;
        end else begin
          overflow_d = 1'b1;
        end
`else
        overflow_d = 1'b1;
`endif
      end
    end

    out_level_d = (state_d == ST_ON);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_level_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_level_q <= out_level_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef EVENT_STRETCHER_QUEUE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
`else
  assign pending = '0;
`endif

  assign out_level = out_level_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_event_stretcher.sv
// Scoreboard bench for event_stretcher: expected output events are queued per scenario,
// a negedge monitor pops and compares every change it observes on the DUT outputs.
module tb_event_stretcher;

  localparam int ON_C = 4;
  localparam int GAP_C = 2;
  localparam int MAXP = 2;
  localparam int PW = $clog2(MAXP + 1);

  localparam int K_LVL  = 0;
  localparam int K_BUSY = 1;
  localparam int K_PEND = 2;
  localparam int K_OVF  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          trigger = 1'b0;
  logic          clear = 1'b0;
  logic          out_level;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  event_stretcher #(
    .ON_CYCLES   (ON_C),
    .GAP_CYCLES  (GAP_C),
    .MAX_PENDING (MAXP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .trigger   (trigger),
    .clear     (clear),
    .out_level (out_level),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int k;
    int v;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  t0 = 0;
  bit  mon_en = 1'b0;
  logic          prev_l;
  logic          prev_b;
  logic [PW-1:0] prev_p;

  function automatic string kname(input int k);
    case (k)
      K_LVL:   return "out_level";
      K_BUSY:  return "busy";
      K_PEND:  return "pending";
      default: return "overflow";
    endcase
  endfunction

  function automatic void ex(input int c, input int k, input int v);
    ev_t e;
    e.c = c;
    e.k = k;
    e.v = v;
    exp_q.push_back(e);
  endfunction

  task automatic got(input int k, input int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s=%0d at cycle %0d, required no event",
               kname(k), v, cyc - t0);
    end else begin
      e = exp_q.pop_front();
      if (e.c != cyc - t0 || e.k != k || e.v != v) begin
        errors++;
        $display("FAIL event_order: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                 kname(k), v, cyc - t0, kname(e.k), e.v, e.c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_level !== prev_l) got(K_LVL, int'(out_level));
      if (busy !== prev_b) got(K_BUSY, int'(busy));
      if (pending !== prev_p) got(K_PEND, int'(pending));
      if (overflow) got(K_OVF, 1);
      prev_l = out_level;
      prev_b = busy;
      prev_p = pending;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_rel(input int r);
    while (cyc < t0 + r) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic trig(input int r);
    wait_rel(r);
    trigger = 1'b1;
    wait_rel(r + 1);
    trigger = 1'b0;
  endtask

  task automatic clr_trig(input int r);
    wait_rel(r);
    trigger = 1'b1;
    clear = 1'b1;
    wait_rel(r + 1);
    trigger = 1'b0;
    clear = 1'b0;
  endtask

  task automatic start_test();
    exp_q.delete();
    t0 = cyc;
  endtask

  task automatic finish_test(input string name);
    wait_rel(40);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: got %0d events still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("reset_out_level", int'(out_level), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_overflow", int'(overflow), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    prev_l = out_level;
    prev_b = busy;
    prev_p = pending;
    mon_en = 1'b1;

    // single trigger
    start_test();
    ex(11, K_LVL, 1); ex(11, K_BUSY, 1); ex(15, K_LVL, 0); ex(17, K_BUSY, 0);
    trig(10);
    finish_test("single");

    // triggers at 10, 12, 13
    start_test();
`ifdef EVENT_STRETCHER_QUEUE_EN
    ex(11, K_LVL, 1); ex(11, K_BUSY, 1); ex(13, K_PEND, 1); ex(14, K_PEND, 2);
    ex(15, K_LVL, 0); ex(17, K_LVL, 1); ex(17, K_PEND, 1); ex(21, K_LVL, 0);
    ex(23, K_LVL, 1); ex(23, K_PEND, 0); ex(27, K_LVL, 0); ex(29, K_BUSY, 0);
`else
    ex(11, K_LVL, 1); ex(11, K_BUSY, 1); ex(13, K_OVF, 1); ex(14, K_OVF, 1);
    ex(15, K_LVL, 0); ex(17, K_BUSY, 0);
`endif
    trig(10); trig(12); trig(13);
    finish_test("three");

    // four triggers back to back: the last one overflows the queue
    start_test();
`ifdef EVENT_STRETCHER_QUEUE_EN
    ex(11, K_LVL, 1); ex(11, K_BUSY, 1); ex(12, K_PEND, 1); ex(13, K_PEND, 2);
    ex(14, K_OVF, 1); ex(15, K_LVL, 0); ex(17, K_LVL, 1); ex(17, K_PEND, 1);
    ex(21, K_LVL, 0); ex(23, K_LVL, 1); ex(23, K_PEND, 0); ex(27, K_LVL, 0);
    ex(29, K_BUSY, 0);
`else
    ex(11, K_LVL, 1); ex(11, K_BUSY, 1); ex(12, K_OVF, 1); ex(13, K_OVF, 1);
    ex(14, K_OVF, 1); ex(15, K_LVL, 0); ex(17, K_BUSY, 0);
`endif
    trig(10); trig(11); trig(12); trig(13);
    finish_test("overflow");

    // trigger on last GAP cycle with nothing pending
    start_test();
    ex(11, K_LVL, 1); ex(11, K_BUSY, 1); ex(15, K_LVL, 0); ex(17, K_LVL, 1);
    ex(21, K_LVL, 0); ex(23, K_BUSY, 0);
    trig(10); trig(16);
    finish_test("last_gap_empty");

    // trigger on last GAP cycle with one pending
    start_test();
`ifdef EVENT_STRETCHER_QUEUE_EN
    ex(11, K_LVL, 1); ex(11, K_BUSY, 1); ex(13, K_PEND, 1); ex(15, K_LVL, 0);
    ex(17, K_LVL, 1); ex(21, K_LVL, 0); ex(23, K_LVL, 1); ex(23, K_PEND, 0);
    ex(27, K_LVL, 0); ex(29, K_BUSY, 0);
`else
    ex(11, K_LVL, 1); ex(11, K_BUSY, 1); ex(13, K_OVF, 1); ex(15, K_LVL, 0);
    ex(17, K_LVL, 1); ex(21, K_LVL, 0); ex(23, K_BUSY, 0);
`endif
    trig(10); trig(12); trig(16);
    finish_test("last_gap_pending");

    // clear with trigger mid-ON
    start_test();
`ifdef EVENT_STRETCHER_QUEUE_EN
    ex(11, K_LVL, 1); ex(11, K_BUSY, 1); ex(12, K_PEND, 1); ex(13, K_PEND, 2);
    ex(14, K_LVL, 0); ex(14, K_BUSY, 0); ex(14, K_PEND, 0);
`else
    ex(11, K_LVL, 1); ex(11, K_BUSY, 1); ex(12, K_OVF, 1); ex(13, K_OVF, 1);
    ex(14, K_LVL, 0); ex(14, K_BUSY, 0);
`endif
    trig(10); trig(11); trig(12); clr_trig(13);
    finish_test("clear");

    // asynchronous reset mid-ON, between clock edges
    start_test();
`ifdef EVENT_STRETCHER_QUEUE_EN
    ex(11, K_LVL, 1); ex(11, K_BUSY, 1); ex(12, K_PEND, 1);
    ex(13, K_LVL, 0); ex(13, K_BUSY, 0); ex(13, K_PEND, 0);
`else
    ex(11, K_LVL, 1); ex(11, K_BUSY, 1); ex(12, K_OVF, 1);
    ex(13, K_LVL, 0); ex(13, K_BUSY, 0);
`endif
    trig(10); trig(11); trig(12);
    wait_rel(13);
    #1 reset = 1'b1;
    #1;
    chk("async_out_level", int'(out_level), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_pending", int'(pending), 0);
    chk("async_overflow", int'(overflow), 0);
    wait_rel(15);
    reset = 1'b0;
    finish_test("reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
